// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader sitting on the SoC shared bus. A start pulse
// takes the bus from the CPU (cpu_hold). The loader then accepts a
// length-prefixed, checksummed byte stream. The stream has this layout:
//     L, L*(WORD_W/8) payload bytes (little-endian per word), C
// where C = (L + sum of payload bytes) mod 256.
// Payload bytes are assembled into words and written to consecutive RAM
// addresses starting at BASE_ADDR. The address wraps modulo 2^ADDR_W.
// At the end of the transfer the loader releases the bus and pulses done
// (checksum matched) or err (checksum mismatch).
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   start          : one-cycle load request, honoured only when idle
//   in_valid/in_ready/in_data : byte source handshake
//   cpu_hold       : CPU must release the bus while high
//   addr_out/data_out/bus_oe/wr_en : registered RAM write port
//   done/err       : one-cycle completion pulses
//   words_loaded   : word count of the last load, held until next start
// ---------------------------------------------------------------------------
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module prog_loader #(
    parameter int ADDR_W    = `ADDR_SIZE,
    parameter int WORD_W    = `WORD_SIZE,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] addr_out,
    output logic [WORD_W-1:0] data_out,
    output logic              bus_oe,
    output logic              wr_en,
    output logic              done,
    output logic              err,
    output logic [8:0]        words_loaded
);

    localparam int BPW    = WORD_W / 8;
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]        state_reg, state_next;
    logic [7:0]        len_reg, len_next;
    logic [7:0]        sum_reg, sum_next;
    logic [BIDX_W-1:0] bidx_reg, bidx_next;
    logic [7:0]        widx_reg, widx_next;
    logic [WORD_W-1:0] word_reg, word_next;
    logic [8:0]        words_loaded_reg, words_loaded_next;
    logic              match_reg, match_next;
    logic              bus_oe_reg, bus_oe_next;
    logic [ADDR_W-1:0] addr_out_reg, addr_out_next;
    logic [WORD_W-1:0] data_out_reg, data_out_next;

    logic              ready_w;
    logic              xfer;
    logic              last_byte;
    logic [WORD_W-1:0] word_merged;
    logic [ADDR_W-1:0] addr_calc;
    logic [8:0]        widx_inc;

    // Handshake readiness is a pure decode of the state register, so it never
    // combinationally depends on in_valid.
    assign ready_w   = (state_reg == S_LEN) || (state_reg == S_DATA) ||
                       (state_reg == S_CSUM);
    assign xfer      = in_valid && ready_w;
    assign last_byte = (bidx_reg == BIDX_W'(BPW - 1));
    assign widx_inc  = {1'b0, widx_reg} + 9'd1;

    // Address arithmetic is done directly in ADDR_W bits, which gives the
    // modulo-2^ADDR_W wrap for free.
    assign addr_calc = ADDR_W'(BASE_ADDR) + ADDR_W'(widx_reg);

    // Current word with the incoming byte dropped into lane bidx.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            assign word_merged[gi*8 +: 8] = (bidx_reg == BIDX_W'(gi)) ?
                                            in_data : word_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        len_next          = len_reg;
        sum_next          = sum_reg;
        bidx_next         = bidx_reg;
        widx_next         = widx_reg;
        word_next         = word_reg;
        words_loaded_next = words_loaded_reg;
        match_next        = match_reg;
        bus_oe_next       = 1'b0;
        addr_out_next     = '0;
        data_out_next     = '0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next        = S_LEN;
                    sum_next          = '0;
                    bidx_next         = '0;
                    widx_next         = '0;
                    word_next         = '0;
                    words_loaded_next = '0;
                    match_next        = 1'b0;
                end
            end

            S_LEN: begin
                if (xfer) begin
                    len_next   = in_data;
                    sum_next   = in_data;
                    state_next = (in_data == 8'd0) ? S_CSUM : S_DATA;
                end
            end

            S_DATA: begin
                if (xfer) begin
                    word_next = word_merged;
                    sum_next  = sum_reg + in_data;
                    if (last_byte) begin
                        // Write port registers load together on entry to
                        // WRITE so address, data and strobes align.
                        bidx_next     = '0;
                        state_next    = S_WRITE;
                        bus_oe_next   = 1'b1;
                        addr_out_next = addr_calc;
                        data_out_next = word_merged;
                    end else begin
                        bidx_next = bidx_reg + BIDX_W'(1);
                    end
                end
            end

            S_WRITE: begin
                widx_next         = widx_inc[7:0];
                words_loaded_next = words_loaded_reg + 9'd1;
                state_next        = (widx_inc == {1'b0, len_reg}) ? S_CSUM : S_DATA;
            end

            S_CSUM: begin
                if (xfer) begin
                    match_next = (in_data == sum_reg);
                    state_next = S_FIN;
                end
            end

            S_FIN: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            len_reg          <= '0;
            sum_reg          <= '0;
            bidx_reg         <= '0;
            widx_reg         <= '0;
            word_reg         <= '0;
            words_loaded_reg <= '0;
            match_reg        <= 1'b0;
            bus_oe_reg       <= 1'b0;
            addr_out_reg     <= '0;
            data_out_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            len_reg          <= len_next;
            sum_reg          <= sum_next;
            bidx_reg         <= bidx_next;
            widx_reg         <= widx_next;
            word_reg         <= word_next;
            words_loaded_reg <= words_loaded_next;
            match_reg        <= match_next;
            bus_oe_reg       <= bus_oe_next;
            addr_out_reg     <= addr_out_next;
            data_out_reg     <= data_out_next;
        end
    end

    assign in_ready     = ready_w;
    assign cpu_hold     = (state_reg != S_IDLE);
    assign bus_oe       = bus_oe_reg;
    assign wr_en        = bus_oe_reg;
    assign addr_out     = addr_out_reg;
    assign data_out     = data_out_reg;
    assign done         = (state_reg == S_FIN) && match_reg;
    assign err          = (state_reg == S_FIN) && !match_reg;
    assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Two loader instances share clk/rst:
//   dut_a : WORD_W=8,  ADDR_W=8, BASE_ADDR=0 (byte-wide directed vectors)
//   dut_b : WORD_W=16, ADDR_W=3, BASE_ADDR=6 (word assembly, address wrap)
// A select variable steers the stimulus to one instance. The expected RAM
// writes and the done/err outcome come from the byte stream itself.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    int   sel = 0;

    always #5 clk = ~clk;

    logic       rdy_a, hold_a, oe_a, we_a, done_a, err_a;
    logic [7:0] addr_a;
    logic [7:0] data_a;
    logic [8:0] wl_a;

    logic        rdy_b, hold_b, oe_b, we_b, done_b, err_b;
    logic [2:0]  addr_b;
    logic [15:0] data_b;
    logic [8:0]  wl_b;

    prog_loader #(.ADDR_W(8), .WORD_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst),
        .start(start && sel == 0), .in_valid(in_valid && sel == 0),
        .in_data(in_data), .in_ready(rdy_a), .cpu_hold(hold_a),
        .addr_out(addr_a), .data_out(data_a), .bus_oe(oe_a), .wr_en(we_a),
        .done(done_a), .err(err_a), .words_loaded(wl_a)
    );

    prog_loader #(.ADDR_W(3), .WORD_W(16), .BASE_ADDR(6)) dut_b (
        .clk(clk), .rst(rst),
        .start(start && sel == 1), .in_valid(in_valid && sel == 1),
        .in_data(in_data), .in_ready(rdy_b), .cpu_hold(hold_b),
        .addr_out(addr_b), .data_out(data_b), .bus_oe(oe_b), .wr_en(we_b),
        .done(done_b), .err(err_b), .words_loaded(wl_b)
    );

    // Views of the selected instance
    logic       in_ready, cpu_hold, bus_oe, wr_en, done, err;
    logic [8:0] words_loaded;
    assign in_ready     = (sel == 1) ? rdy_b  : rdy_a;
    assign cpu_hold     = (sel == 1) ? hold_b : hold_a;
    assign bus_oe       = (sel == 1) ? oe_b   : oe_a;
    assign wr_en        = (sel == 1) ? we_b   : we_a;
    assign done         = (sel == 1) ? done_b : done_a;
    assign err          = (sel == 1) ? err_b  : err_a;
    assign words_loaded = (sel == 1) ? wl_b   : wl_a;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed RAM writes, {addr, data}
    logic [31:0] wr_q_a[$];
    logic [31:0] wr_q_b[$];
    logic prev_we_a = 1'b0;
    logic prev_we_b = 1'b0;

    always @(negedge clk) begin
        if (we_a) begin
            wr_q_a.push_back({8'd0, addr_a, 8'd0, data_a});
            check("a_bus_oe_with_wr", {31'd0, oe_a}, 32'd1);
            check("a_wr_pulse_single", {31'd0, prev_we_a}, 32'd0);
        end
        if (we_b) begin
            wr_q_b.push_back({13'd0, addr_b, data_b});
            check("b_bus_oe_with_wr", {31'd0, oe_b}, 32'd1);
            check("b_wr_pulse_single", {31'd0, prev_we_b}, 32'd0);
        end
        prev_we_a = we_a;
        prev_we_b = we_b;
    end

    logic [7:0] stream_q[$];

    // Offer one byte and return at the negedge after it has transferred.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int cnt;
        int gap;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("ready_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("wl_cleared", {23'd0, words_loaded}, 32'd0);
    endtask

    // Run stream_q on the selected instance and compare with the model.
    task automatic run_load(input int s, input int max_gap);
        int bpw, aw, base, len, csum_calc, nb;
        bit good;
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        logic [31:0] d;
        sel = s;
        bpw  = (s == 1) ? 2 : 1;
        aw   = (s == 1) ? 3 : 8;
        base = (s == 1) ? 6 : 0;
        nb   = stream_q.size();
        len  = stream_q[0];
        csum_calc = 0;
        for (int i = 0; i < nb - 1; i++) csum_calc = (csum_calc + stream_q[i]) % 256;
        good = (csum_calc == int'(stream_q[nb-1]));
        for (int w = 0; w < len; w++) begin
            d = 0;
            for (int k = 0; k < bpw; k++) d = d | (32'(stream_q[1 + w*bpw + k]) << (8*k));
            exp_q.push_back((32'((base + w) % (1 << aw)) << 16) | d);
        end
        wr_q_a.delete();
        wr_q_b.delete();

        do_start();
        for (int i = 0; i < nb; i++) send_byte(stream_q[i], max_gap);
        check("done_pulse", {31'd0, done}, {31'd0, good});
        check("err_pulse", {31'd0, err}, {31'd0, !good});
        @(negedge clk);
        check("done_drop", {31'd0, done}, 32'd0);
        check("err_drop", {31'd0, err}, 32'd0);
        check("hold_released", {31'd0, cpu_hold}, 32'd0);
        check("words_loaded", {23'd0, words_loaded}, 32'(len));
        got_q = (s == 1) ? wr_q_b : wr_q_a;
        check("wr_count", 32'(got_q.size()), 32'(len));
        for (int i = 0; i < len && i < got_q.size(); i++)
            check($sformatf("wr_%0d", i), got_q[i], exp_q[i]);
        $display("load dut%0d L=%0d gap<=%0d csum_ok=%0d writes=%0d done=%0d", s, len, max_gap,
                 good, got_q.size(), good);
    endtask

    initial begin
        int len, bpw, sum;
        logic [7:0] b;

        // Reset then idle
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            @(negedge clk);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
            check("rst_bus", {29'd0, bus_oe, wr_en, done | err}, 32'd0);
            check("rst_wl", {23'd0, words_loaded}, 32'd0);
        end
        check("rst_addr_data", {addr_a, data_a, 5'd0, addr_b, 8'd0} | {16'd0, data_b}, 32'd0);
        $display("reset idle check complete");
        in_valid = 1'b0;

        // Good load
        stream_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_load(0, 0);
        // Bad checksum
        stream_q = '{8'h02, 8'hAA, 8'h55, 8'h00};
        run_load(0, 0);
        // Zero length
        stream_q = '{8'h00, 8'h00};
        run_load(0, 0);
        // Source stalls
        stream_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_load(0, 3);
        run_load(0, 3);

        // Reset during DATA
        sel = 0;
        wr_q_a.delete();
        do_start();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("pre_rst_hold", {31'd0, cpu_hold}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("mid_rst_bus_oe", {31'd0, bus_oe}, 32'd0);
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        $display("reset during DATA applied");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stream_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_load(0, 1);

        // Randomized loads on both instances
        for (int t = 0; t < 12; t++) begin
            int s;
            s   = t % 2;
            bpw = (s == 1) ? 2 : 1;
            len = $urandom_range(6, 0);
            stream_q.delete();
            stream_q.push_back(8'(len));
            sum = len;
            for (int i = 0; i < len * bpw; i++) begin
                b = 8'($urandom_range(255, 0));
                stream_q.push_back(b);
                sum = sum + b;
            end
            b = 8'(sum % 256);
            if ($urandom_range(3, 0) == 0) b = b ^ 8'($urandom_range(255, 1));
            stream_q.push_back(b);
            run_load(s, $urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader on the SoC shared bus, between an external byte source and the RAM. On a start pulse it asserts `cpu_hold` to take the address/data bus from the CPU. It then receives a length-prefixed, checksummed byte stream over a valid/ready handshake, assembles bytes into words and writes them into consecutive RAM locations. When the transfer ends it releases the bus and reports done or error.

## Interface
- `ADDR_W`, default `` `ADDR_SIZE ``: width of the RAM address driven onto the address bus.
- `WORD_W`, default `` `WORD_SIZE ``: RAM word width. Must be a multiple of 8.
- `BASE_ADDR`, default 0: RAM address of the first loaded word.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load. Ignored unless the FSM is in IDLE.
- `in_valid` in 1: source has a byte on `in_data`.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `cpu_hold` out 1: CPU must tristate its bus drivers and stall while this is high.
- `addr_out` out ADDR_W: RAM address. Meaningful when `bus_oe` is high.
- `data_out` out WORD_W: RAM write data. Meaningful when `bus_oe` is high.
- `bus_oe` out 1: top level drives `addr_out`/`data_out` onto the shared buses when high.
- `wr_en` out 1: RAM write strobe.
- `done` out 1: one-cycle pulse, load completed and checksum matched.
- `err` out 1: one-cycle pulse, checksum mismatch.
- `words_loaded` out 9: number of words written in the last load. Held until the next `start`.

## Operation
- Stream format: byte L (word count, 0..255), then L×(WORD_W/8) payload bytes (little-endian within each word), then checksum byte C.
- C = (L + sum of all payload bytes) mod 256.
- States: IDLE, LEN, DATA, WRITE, CSUM, FIN.
  - IDLE: all outputs 0. On `start`, go to LEN and set `cpu_hold`=1. Clear the running sum, byte index, word index and `words_loaded`.
  - LEN: `in_ready`=1. On a transfer, latch L and set sum=L. If L=0 go to CSUM, else go to DATA.
  - DATA: `in_ready`=1. Each transfer shifts the byte into the word register at byte position `bidx` and adds it to the sum (8-bit wrap). When the last byte of a word transfers, go to WRITE.
  - WRITE: `in_ready`=0, `bus_oe`=1 and `wr_en`=1 for exactly one cycle. `addr_out` = (BASE_ADDR + widx) mod 2^ADDR_W; `data_out` = the assembled word. Then increment `widx` and `words_loaded`. If `widx`+1 = L go to CSUM, else go to DATA.
  - CSUM: `in_ready`=1. On a transfer, compare the byte with the sum and go to FIN.
  - FIN: one cycle. Pulse `done` on a match or `err` on a mismatch. Drop `cpu_hold`, go to IDLE.
- Words written before a checksum error stay in RAM. No rollback.
- Address wraps modulo 2^ADDR_W without error.
- `start` while not in IDLE is ignored.
- `in_valid` without `in_ready` holds the byte at the source. No byte is dropped or duplicated.

## Timing
- Reset value of every output is 0. `words_loaded` resets to 0. FSM resets to IDLE.
- Reset mid-load: outputs go to 0 immediately (asynchronous). Any RAM write in progress is abandoned, and `cpu_hold` drops at once.
- `cpu_hold` rises in the cycle after `start` is sampled. It falls in the cycle after FIN.
- `bus_oe`, `wr_en`, `addr_out` and `data_out` are all registered. They change together at the clock edge that enters WRITE and clear at the edge that leaves it.
- Maximum throughput is one byte per cycle. Each word costs WORD_W/8 + 1 cycles (one stall cycle for WRITE).
- Latency from the checksum-byte transfer to the `done`/`err` pulse is 1 cycle.
- `in_ready` is a registered function of state only. It does not depend on `in_valid`.

## Test plan
- Reset then idle: hold `rst`=1 for 3 cycles, then release → all outputs 0. `in_ready`=0 with `in_valid`=1.
- Good load, WORD_W=8, BASE_ADDR=0: `start`, then stream 03, 11, 22, 33, 69 → RAM[0..2] = 11, 22, 33. Exactly 3 `wr_en` pulses. `done`=1 for one cycle. `words_loaded`=3. `cpu_hold` low afterwards.
- Bad checksum: stream 02, AA, 55, 00 → both words are written. `err`=1 for one cycle (expected sum 01). `done` stays 0.
- Zero length: stream 00, 00 → no `wr_en`, `done` pulses, `words_loaded`=0.
- Source stalls: insert 0–3 idle cycles at random between bytes of the good-load stream → same RAM contents and the same `done` result. Each `wr_en` pulse is exactly one cycle.
- Reset during DATA: assert `rst` after 2 payload bytes → `cpu_hold`, `bus_oe` and `wr_en` go to 0 immediately. A following full load (new `start`) completes with `done`.
